// File: rtl/qbus_pkg.sv
// ----------------------------------------------------------------------------
// qbus_pkg : shared state encoding and lane constants for qbus_slave_sync
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package qbus_pkg;

  localparam int DAL_W  = 22;
  localparam int DATA_W = 16;

  localparam logic [1:0] BYTE_LO   = 2'b01;
  localparam logic [1:0] BYTE_HI   = 2'b10;
  localparam logic [1:0] BYTE_BOTH = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_RD   = 3'd2,
    ST_WR   = 3'd3,
    ST_NEG  = 3'd4,
    ST_CONT = 3'd5,
    ST_NXM  = 3'd6
  } qbus_state_t;

  // A byte write (WTBT in the data phase) selects the lane named by address bit 0.
  function automatic logic [1:0] byte_lanes(input logic wtbt, input logic odd);
    if (!wtbt) return BYTE_BOTH;
    return odd ? BYTE_HI : BYTE_LO;
  endfunction

endpackage

`default_nettype wire

// File: rtl/qbus_sync_bit.sv
// ----------------------------------------------------------------------------
// qbus_sync_bit : STAGES-deep single-bit synchroniser exposing its first flop
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module qbus_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic first,
  output logic q
);

  logic [STAGES-1:0] stages;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stages <= '0;
    else     stages <= {stages[STAGES-2:0], d};
  end

  assign first = stages[0];
  assign q     = stages[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/qbus_slave_sync.sv
// ----------------------------------------------------------------------------
// qbus_slave_sync : QBUS slave cycles onto the qclk-synchronous I/O register bus
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module qbus_slave_sync
  import qbus_pkg::*;
#(
  parameter int AW          = 13,
  parameter int SYNC_STAGES = 2,
  parameter int BLOCK_EN    = 1,
  parameter int BLOCK_MAX   = 16
) (
  input  logic              qclk,
  input  logic              reset,
  output logic              DALtx,
  inout  wire  [DAL_W-1:0]  DAL,
  input  logic              RBS7,
  input  logic              RWTBT,
  input  logic              RSYNC,
  input  logic              RDIN,
  input  logic              RDOUT,
  input  logic              RINIT,
  output logic              TRPLY,
  output logic              TREF,
  output logic [AW-1:0]     iADDR,
  output logic              iBS7,
  output logic              iREAD,
  input  logic              iREAD_MATCH,
  input  logic [DATA_W-1:0] iRDATA,
  output logic              iWRITE,
  input  logic              iWRITE_MATCH,
  output logic [DATA_W-1:0] iWDATA,
  output logic [1:0]        iBYTE
);

  localparam int            CW      = $clog2(BLOCK_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(BLOCK_MAX);
  localparam logic [CW-1:0] CNT_REF = CW'(BLOCK_MAX - 1);

  logic s_sync, s_din, s_dout, s_init;
  logic sync_first;
  logic din_first_unused, dout_first_unused, init_first_unused;

  qbus_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_sync (
    .clk(qclk), .rst(reset), .d(RSYNC), .first(sync_first), .q(s_sync));
  qbus_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_din (
    .clk(qclk), .rst(reset), .d(RDIN), .first(din_first_unused), .q(s_din));
  qbus_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_dout (
    .clk(qclk), .rst(reset), .d(RDOUT), .first(dout_first_unused), .q(s_dout));
  qbus_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_init (
    .clk(qclk), .rst(reset), .d(RINIT), .first(init_first_unused), .q(s_init));

  qbus_state_t       state;
  logic [1:0]        step;
  logic              last_wr;
  logic [CW-1:0]     word_cnt;
  logic              sync_d;
  logic [DATA_W-1:0] dal_out;

  // Address is grabbed as the first RSYNC flop loads, while the master still holds it on DAL.
  logic sync_raw_rise;
  assign sync_raw_rise = RSYNC & ~sync_first;

  logic block_ok;
  assign block_ok = (BLOCK_EN != 0) && (word_cnt < CNT_REF);

  assign DAL = DALtx ? {{(DAL_W-DATA_W){1'b0}}, dal_out} : {DAL_W{1'bz}};

  always_ff @(posedge qclk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      step     <= 2'd0;
      last_wr  <= 1'b0;
      word_cnt <= '0;
      sync_d   <= 1'b0;
      dal_out  <= '0;
      DALtx    <= 1'b0;
      TRPLY    <= 1'b0;
      TREF     <= 1'b0;
      iREAD    <= 1'b0;
      iWRITE   <= 1'b0;
      iADDR    <= '0;
      iBS7     <= 1'b0;
      iWDATA   <= '0;
      iBYTE    <= BYTE_BOTH;
    end else begin
      iREAD  <= 1'b0;
      iWRITE <= 1'b0;
      sync_d <= s_sync;
      if (sync_raw_rise) begin
        iADDR <= DAL[AW-1:0];
        iBS7  <= RBS7;
      end
      if (s_init || !s_sync) begin
        state <= ST_IDLE;
        DALtx <= 1'b0;
        TRPLY <= 1'b0;
        TREF  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            // Only a fresh SYNC starts a cycle; a SYNC still high after INIT is ignored.
            if (!sync_d) begin
              state    <= ST_ADDR;
              word_cnt <= '0;
            end
          end
          ST_ADDR: begin
            if (s_din) begin
              iREAD   <= 1'b1;
              last_wr <= 1'b0;
              step    <= 2'd0;
              state   <= ST_RD;
            end else if (s_dout) begin
              iWDATA  <= DAL[DATA_W-1:0];
              iBYTE   <= byte_lanes(RWTBT, iADDR[0]);
              last_wr <= 1'b1;
              if (iWRITE_MATCH) begin
                iWRITE <= 1'b1;
                state  <= ST_WR;
              end else begin
                state <= ST_NXM;
              end
            end
          end
          ST_RD: begin
            case (step)
              2'd0: begin
                if (iREAD_MATCH) step  <= 2'd1;
                else             state <= ST_NXM;
              end
              2'd1: begin
                dal_out <= iRDATA;
                DALtx   <= 1'b1;
                step    <= 2'd2;
              end
              default: begin
                TRPLY <= 1'b1;
                TREF  <= block_ok;
                state <= ST_NEG;
              end
            endcase
          end
          ST_WR: begin
            TRPLY <= 1'b1;
            TREF  <= block_ok;
            state <= ST_NEG;
          end
          ST_NEG: begin
            if (!s_din && !s_dout) begin
              TRPLY <= 1'b0;
              TREF  <= 1'b0;
              DALtx <= 1'b0;
              if (word_cnt != CNT_MAX) word_cnt <= word_cnt + 1'b1;
              state <= ST_CONT;
            end
          end
          ST_CONT: begin
            if (s_din || s_dout) begin
              // Opposite direction (read after write or write after read) reuses the address.
              if (s_din == last_wr) begin
                state <= ST_ADDR;
              end else if ((BLOCK_EN != 0) && (word_cnt < CNT_MAX)) begin
                iADDR <= iADDR + AW'(2);
                state <= ST_ADDR;
              end else begin
                state <= ST_NXM;
              end
            end
          end
          ST_NXM: begin
            state <= ST_NXM;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_qbus_slave_sync.sv
// ----------------------------------------------------------------------------
// tb_qbus_slave_sync : directed QBUS cycles against a small register-file model
// rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_qbus_slave_sync;
  import qbus_pkg::*;

  localparam int AW = 13;

  logic qclk  = 1'b0;
  logic reset = 1'b1;
  logic RBS7 = 1'b0, RWTBT = 1'b0, RSYNC = 1'b0, RDIN = 1'b0, RDOUT = 1'b0, RINIT = 1'b0;
  logic DALtx, TRPLY, TREF, iREAD, iWRITE, iBS7;
  logic [AW-1:0] iADDR;
  logic [15:0]   iWDATA;
  logic [15:0]   iRDATA;
  logic [1:0]    iBYTE;
  logic          iREAD_MATCH, iWRITE_MATCH;
  tri   [21:0]   DAL;
  logic [21:0]   dal_drv = '0;
  logic          dal_oe  = 1'b0;

  assign DAL = dal_oe ? dal_drv : 'z;

  always #5 qclk = ~qclk;

  qbus_slave_sync #(.AW(AW), .SYNC_STAGES(2), .BLOCK_EN(1), .BLOCK_MAX(4)) dut (
    .qclk(qclk), .reset(reset), .DALtx(DALtx), .DAL(DAL),
    .RBS7(RBS7), .RWTBT(RWTBT), .RSYNC(RSYNC), .RDIN(RDIN), .RDOUT(RDOUT), .RINIT(RINIT),
    .TRPLY(TRPLY), .TREF(TREF), .iADDR(iADDR), .iBS7(iBS7),
    .iREAD(iREAD), .iREAD_MATCH(iREAD_MATCH), .iRDATA(iRDATA),
    .iWRITE(iWRITE), .iWRITE_MATCH(iWRITE_MATCH), .iWDATA(iWDATA), .iBYTE(iBYTE));

  // Register file: four words at 'o440..'o446 and one at 'o560, I/O page only.
  logic [15:0] regs [0:4];
  logic [2:0]  reg_idx;
  logic        reg_hit;
  int          wr_pulses = 0;
  int          overlap   = 0;

  always_comb begin
    reg_hit = 1'b0;
    reg_idx = 3'd0;
    if (iBS7 && iADDR[AW-1:3] == 10'o044) begin
      reg_hit = 1'b1;
      reg_idx = {1'b0, iADDR[2:1]};
    end else if (iBS7 && iADDR[AW-1:1] == 12'o270) begin
      reg_hit = 1'b1;
      reg_idx = 3'd4;
    end
  end

  assign iREAD_MATCH  = reg_hit;
  assign iWRITE_MATCH = reg_hit;

  always @(posedge qclk) begin
    if (reset) begin
      regs[0] <= 16'o123456;
      regs[1] <= 16'o111111;
      regs[2] <= 16'o122222;
      regs[3] <= 16'o133333;
      regs[4] <= 16'o123456;
      iRDATA  <= 16'h0000;
    end else begin
      if (iREAD) iRDATA <= regs[reg_idx];
      if (iWRITE && reg_hit) begin
        if (iBYTE[0]) regs[reg_idx][7:0]  <= iWDATA[7:0];
        if (iBYTE[1]) regs[reg_idx][15:8] <= iWDATA[15:8];
      end
    end
    if (iWRITE)          wr_pulses <= wr_pulses + 1;
    if (iREAD && iWRITE) overlap   <= overlap + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge qclk);
    #1;
  endtask

  task automatic bus_start(input logic [21:0] addr, input logic bs7, input logic wtbt);
    dal_drv = addr; dal_oe = 1'b1; RBS7 = bs7; RWTBT = wtbt;
    cyc(1);
    RSYNC = 1'b1;
    cyc(2);
    dal_oe = 1'b0; RBS7 = 1'b0; RWTBT = 1'b0;
  endtask

  task automatic bus_end();
    RSYNC = 1'b0; RDIN = 1'b0; RDOUT = 1'b0; dal_oe = 1'b0; RWTBT = 1'b0;
    cyc(5);
  endtask

  task automatic wait_rply(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (TRPLY) ok = 1'b1;
      else       cyc(1);
    end
  endtask

  task automatic din_word(output logic ok, output logic [21:0] data, output logic tref,
                          output logic [AW-1:0] addr, output int rel_cyc);
    logic released;
    RDIN = 1'b1;
    wait_rply(ok);
    data = DAL; tref = TREF; addr = iADDR;
    RDIN = 1'b0;
    released = 1'b0;
    rel_cyc  = 0;
    for (int i = 0; i < 10 && !released; i++) begin
      cyc(1);
      rel_cyc++;
      if (!TRPLY && !DALtx) released = 1'b1;
    end
    if (!released) rel_cyc = -1;
  endtask

  task automatic dout_word(input logic [15:0] data, input logic wtbt, output logic ok);
    dal_drv = {6'b0, data}; dal_oe = 1'b1; RWTBT = wtbt; RDOUT = 1'b1;
    wait_rply(ok);
    RDOUT = 1'b0;
    for (int i = 0; i < 10 && TRPLY; i++) cyc(1);
    dal_oe = 1'b0; RWTBT = 1'b0;
  endtask

  task automatic wait_dalx(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (DALtx) ok = 1'b1;
      else       cyc(1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  logic          ok, tref;
  logic [21:0]   data;
  logic [AW-1:0] addr;
  int            rel, p0;
  logic [15:0]   blk_data [0:3];

  initial begin
    blk_data[0] = 16'o177721; blk_data[1] = 16'o111111;
    blk_data[2] = 16'o122222; blk_data[3] = 16'o133333;

    cyc(3);
    check("reset_ctl", {26'd0, DALtx, TRPLY, TREF, iREAD, iWRITE, iBS7}, 32'd0);
    check("reset_addr", iADDR, 32'd0);
    check("reset_wdata", iWDATA, 32'd0);
    check("reset_byte", iBYTE, 32'd3);
    check("reset_state", dut.state, ST_IDLE);
    reset = 1'b0;
    cyc(2);

    // DATI 'o440
    bus_start(22'o440, 1'b1, 1'b0);
    check("dati_addr", iADDR, 32'o440);
    check("dati_bs7", iBS7, 32'd1);
    din_word(ok, data, tref, addr, rel);
    check("dati_rply", ok, 32'd1);
    check("dati_data", data, 32'o123456);
    check("dati_release", rel, 32'd3);
    bus_end();

    // DATO 'o440 then readback
    p0 = wr_pulses;
    bus_start(22'o440, 1'b1, 1'b1);
    dout_word(16'o054321, 1'b0, ok);
    check("dato_rply", ok, 32'd1);
    check("dato_pulses", wr_pulses - p0, 32'd1);
    check("dato_byte", iBYTE, 32'b11);
    check("dato_wdata", iWDATA, 32'o054321);
    bus_end();
    bus_start(22'o440, 1'b1, 1'b0);
    din_word(ok, data, tref, addr, rel);
    check("dato_readback", data, 32'o054321);
    bus_end();

    // DATOB high byte at 'o441
    bus_start(22'o441, 1'b1, 1'b1);
    dout_word(16'o177400, 1'b1, ok);
    check("datob_rply", ok, 32'd1);
    check("datob_byte", iBYTE, 32'b10);
    bus_end();
    bus_start(22'o440, 1'b1, 1'b0);
    din_word(ok, data, tref, addr, rel);
    check("datob_readback", data, 32'o177721);
    bus_end();

    // DATIO 'o560
    bus_start(22'o560, 1'b1, 1'b0);
    din_word(ok, data, tref, addr, rel);
    check("datio_read", data, 32'o123456);
    dout_word(16'o054545, 1'b0, ok);
    check("datio_wrply", ok, 32'd1);
    check("datio_addr", iADDR, 32'o560);
    bus_end();
    bus_start(22'o560, 1'b1, 1'b0);
    din_word(ok, data, tref, addr, rel);
    check("datio_readback", data, 32'o054545);
    bus_end();

    // DATBI from 'o440, four words, then a fifth strobe
    bus_start(22'o440, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      din_word(ok, data, tref, addr, rel);
      check($sformatf("blk_rply%0d", k), ok, 32'd1);
      check($sformatf("blk_addr%0d", k), addr, 32'o440 + 32'(2 * k));
      check($sformatf("blk_data%0d", k), data, {16'd0, blk_data[k]});
      check($sformatf("blk_tref%0d", k), tref, (k < 3) ? 32'd1 : 32'd0);
    end
    RDIN = 1'b1;
    wait_rply(ok);
    check("blk_fifth_norply", ok, 32'd0);
    bus_end();

    // Non-existent addresses
    bus_start(22'o400, 1'b1, 1'b0);
    RDIN = 1'b1;
    wait_rply(ok);
    check("nxm_400", ok, 32'd0);
    check("nxm_400_dalx", DALtx, 32'd0);
    bus_end();
    bus_start(22'o440, 1'b0, 1'b0);
    RDIN = 1'b1;
    wait_rply(ok);
    check("nxm_nobs7", ok, 32'd0);
    bus_end();

    // Reset mid-read
    bus_start(22'o440, 1'b1, 1'b0);
    RDIN = 1'b1;
    wait_dalx(ok);
    check("rst_mid_dalx", ok, 32'd1);
    check("rst_mid_state", dut.state, ST_RD);
    reset = 1'b1;
    #1;
    check("rst_mid_outs", {TRPLY, DALtx}, 32'd0);
    check("rst_mid_idle", dut.state, ST_IDLE);
    RDIN = 1'b0; RSYNC = 1'b0;
    cyc(3);
    reset = 1'b0;
    cyc(2);

    // INIT mid-read
    bus_start(22'o440, 1'b1, 1'b0);
    RDIN = 1'b1;
    wait_dalx(ok);
    check("init_mid_dalx", ok, 32'd1);
    RINIT = 1'b1;
    cyc(4);
    check("init_outs", {TRPLY, DALtx, TREF}, 32'd0);
    check("init_idle", dut.state, ST_IDLE);
    check("init_keeps_addr", iADDR, 32'o440);
    RINIT = 1'b0;
    cyc(4);
    check("init_no_restart", dut.state, ST_IDLE);
    bus_end();

    check("no_rd_wr_overlap", overlap, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
